// File: rtl/uart_stream_pkg.sv
// Shared types and helpers for the UART TX stream arbiter.
// Round-robin search is written for up to MAX_SRC requesters.
package uart_stream_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int MAX_SRC     = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // First set bit of req after 'last', wrapping modulo n; returns 'last' if none.
    function automatic logic [2:0] rr_next(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         last,
                                           input int unsigned        n);
        logic [2:0] sel;
        logic       hit;
        logic [2:0] idx;
        sel = last;
        hit = 1'b0;
        for (int unsigned k = 1; k <= MAX_SRC; k++) begin
            if (!hit && k <= n) begin
                idx = 3'((32'(last) + k) % n);
                if (req[idx]) begin
                    sel = idx;
                    hit = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/stream_rr_picker.sv
// Combinational round-robin pick over NUM_SRC requests.
// 'found' is high when at least one request is present.
module stream_rr_picker
    import uart_stream_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         last,
    output logic [2:0]         pick,
    output logic               found
);

    logic [MAX_SRC-1:0] req_ext;

    for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_ext
        if (gi < NUM_SRC) begin : g_used
            assign req_ext[gi] = req[gi];
        end else begin : g_pad
            assign req_ext[gi] = 1'b0;
        end
    end

    assign pick  = rr_next(req_ext, last, NUM_SRC);
    assign found = |req;

endmodule

// File: rtl/uart_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the UART TX byte stream.
// A grant ends on tlast, burst limit or idle timeout; the output byte register drains independently.
module uart_tx_stream_arbiter
    import uart_stream_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int MAX_BURST    = 64,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NUM_SRC-1:0]             s_tvalid,
    output logic [NUM_SRC-1:0]             s_tready,
    input  logic [UART_BYTE_W*NUM_SRC-1:0] s_tdata,
    input  logic [NUM_SRC-1:0]             s_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [UART_BYTE_W-1:0]         m_tdata,
    output logic [2:0]                     grant_id,
    output logic                           busy
);

    localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    arb_state_t             state_reg, state_next;
    logic [2:0]             grant_reg, grant_next;
    logic [2:0]             last_reg, last_next;
    logic [BURST_W-1:0]     burst_cnt_reg, burst_cnt_next;
    logic [IDLE_W-1:0]      idle_cnt_reg, idle_cnt_next;
    logic                   m_tvalid_reg;
    logic [UART_BYTE_W-1:0] m_tdata_reg;

    logic [NUM_SRC-1:0]     grant_onehot;
    logic [UART_BYTE_W-1:0] sel_data;
    logic                   sel_valid, sel_last;
    logic                   out_ready, xfer, burst_hit, timeout_hit;
    logic [2:0]             pick;
    logic                   found;

    stream_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .req   (s_tvalid),
        .last  (last_reg),
        .pick  (pick),
        .found (found)
    );

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
        assign grant_onehot[gi] = (grant_reg == 3'(gi));
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_onehot[i]) begin
                sel_data = s_tdata[UART_BYTE_W*i +: UART_BYTE_W];
            end
        end
    end

    assign busy      = (state_reg == ARB_GRANT);
    assign sel_valid = |(s_tvalid & grant_onehot);
    assign sel_last  = |(s_tlast & grant_onehot);
    assign out_ready = !m_tvalid_reg || m_tready;
    assign s_tready  = {NUM_SRC{busy && out_ready}} & grant_onehot;
    assign xfer      = busy && sel_valid && out_ready;

    if (MAX_BURST > 0) begin : g_burst
        assign burst_hit = xfer && (({1'b0, burst_cnt_reg} + 1'b1) == (BURST_W + 1)'(MAX_BURST));
    end else begin : g_no_burst
        assign burst_hit = 1'b0;
    end

    // A stalled cycle counts only when the granted source has nothing to offer.
    if (IDLE_TIMEOUT > 0) begin : g_timeout
        assign timeout_hit = busy && !sel_valid &&
                             (({1'b0, idle_cnt_reg} + 1'b1) == (IDLE_W + 1)'(IDLE_TIMEOUT));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        last_next      = last_reg;
        burst_cnt_next = burst_cnt_reg;
        idle_cnt_next  = idle_cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (found) begin
                    grant_next     = pick;
                    last_next      = pick;
                    burst_cnt_next = '0;
                    idle_cnt_next  = '0;
                    state_next     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                    idle_cnt_next  = '0;
                    if (sel_last || burst_hit) begin
                        state_next = ARB_IDLE;
                    end
                end else if (!sel_valid) begin
                    if (idle_cnt_reg != '1) begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                    if (timeout_hit) begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            grant_reg     <= '0;
            last_reg      <= 3'(NUM_SRC - 1);
            burst_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
            m_tvalid_reg  <= 1'b0;
            m_tdata_reg   <= '0;
        end else begin
            grant_reg     <= grant_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
            idle_cnt_reg  <= idle_cnt_next;
            if (xfer) begin
                m_tdata_reg  <= sel_data;
                m_tvalid_reg <= 1'b1;
            end else if (m_tvalid_reg && m_tready) begin
                m_tvalid_reg <= 1'b0;
            end
        end
    end

    assign m_tvalid = m_tvalid_reg;
    assign m_tdata  = m_tdata_reg;
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Scoreboard bench for uart_tx_stream_arbiter: per-source stream drivers,
// expected output bytes queued by the stimulus, checked by an output monitor.
module tb_uart_tx_stream_arbiter;

    localparam int N = 4;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic [N-1:0]  s_tvalid = '0;
    logic [N-1:0]  s_tready;
    logic [8*N-1:0] s_tdata = '0;
    logic [N-1:0]  s_tlast = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [7:0]    m_tdata;
    logic [2:0]    grant_id;
    logic          busy;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      src_q[N][$];
    logic [7:0] exp_q[$];
    logic [2:0] grant_log[$];
    int checks = 0;
    int failures = 0;

    uart_tx_stream_arbiter #(.NUM_SRC(N), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_byte(input int src, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        src_q[src].push_back(b);
    endtask

    task automatic push_pkt(input int src, input logic [7:0] first, input int n, input logic with_last);
        for (int k = 0; k < n; k++) begin
            push_byte(src, first + 8'(k), with_last && (k == n - 1));
        end
    endtask

    task automatic push_exp(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(first + 8'(k));
        end
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        PRESET = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        grant_log.delete();
        @(negedge PCLK);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_m_tdata", m_tdata, 0);
        PRESET = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        bit done = 1'b0;
        bit srcs_empty;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge PCLK);
            srcs_empty = 1'b1;
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) srcs_empty = 1'b0;
            if (exp_q.size() == 0 && srcs_empty && !busy && !m_tvalid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain actual=%0d bytes pending required=0", name, exp_q.size());
        end
    endtask

    task automatic check_grants(input string name, input int n, input logic [2:0] e0,
                                input logic [2:0] e1, input logic [2:0] e2, input logic [2:0] e3,
                                input logic [2:0] e4);
        logic [2:0] exp_g[5];
        exp_g[0] = e0; exp_g[1] = e1; exp_g[2] = e2; exp_g[3] = e3; exp_g[4] = e4;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_grant%0d", name, k),
                  (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFF, 32'(exp_g[k]));
        end
    endtask

    // Source drivers: pop a beat on handshake, then present the next one.
    initial begin : driver
        logic [N-1:0] hs;
        forever begin
            @(negedge PCLK);
            hs = s_tvalid & s_tready;
            @(posedge PCLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) src_q[i].delete(0);
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]       = 1'b1;
                    s_tdata[8*i +: 8] = src_q[i][0].d;
                    s_tlast[i]        = src_q[i][0].l;
                end else begin
                    s_tvalid[i]       = 1'b0;
                    s_tdata[8*i +: 8] = 8'h00;
                    s_tlast[i]        = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge PCLK);
            if (!PRESET && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=0x%02h required=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("m_tdata", m_tdata, e);
                    $display("out byte=0x%02h expected=0x%02h grant_id=%0d", m_tdata, e, grant_id);
                end
            end
        end
    end

    initial begin : grant_logger
        logic busy_d = 1'b0;
        forever begin
            @(negedge PCLK);
            if (busy && !busy_d) grant_log.push_back(grant_id);
            busy_d = busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Single source, latency and release timing
        @(negedge PCLK);
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        @(negedge PCLK);
        check("t1_c0_busy", busy, 0);
        check("t1_c0_s_tready", s_tready, 0);
        @(negedge PCLK);
        check("t1_c1_busy", busy, 1);
        check("t1_c1_grant_id", grant_id, 1);
        check("t1_c1_s_tready", s_tready, 4'b0010);
        @(negedge PCLK);
        check("t1_c2_m_tvalid", m_tvalid, 1);
        check("t1_c2_m_tdata", m_tdata, 8'h11);
        @(negedge PCLK);
        check("t1_c3_busy", busy, 1);
        check("t1_c3_m_tdata", m_tdata, 8'h22);
        @(negedge PCLK);
        check("t1_c4_busy", busy, 0);
        check("t1_c4_m_tdata", m_tdata, 8'h33);
        @(negedge PCLK);
        check("t1_c5_m_tvalid", m_tvalid, 0);
        wait_drain("t1", 50);

        // Fairness: all sources with two 2-byte packets
        do_reset();
        m_tready = 1'b1;
        @(negedge PCLK);
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 8'h40 + 8'(16 * i), 2, 1'b1);
            push_pkt(i, 8'h42 + 8'(16 * i), 2, 1'b1);
        end
        push_exp(8'h40, 2); push_exp(8'h50, 2); push_exp(8'h60, 2); push_exp(8'h70, 2);
        push_exp(8'h42, 2); push_exp(8'h52, 2); push_exp(8'h62, 2); push_exp(8'h72, 2);
        wait_drain("t2", 200);
        check_grants("t2", 5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0);

        // Backpressure for 5 cycles mid-packet
        do_reset();
        m_tready = 1'b1;
        @(negedge PCLK);
        push_pkt(0, 8'hC1, 4, 1'b1);
        push_exp(8'hC1, 4);
        repeat (3) @(negedge PCLK);
        check("t3_c2_m_tdata", m_tdata, 8'hC1);
        @(posedge PCLK);
        #1 m_tready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge PCLK);
            check($sformatf("t3_stall%0d_m_tdata", s), m_tdata, 8'hC2);
            check($sformatf("t3_stall%0d_m_tvalid", s), m_tvalid, 1);
            check($sformatf("t3_stall%0d_s_tready", s), s_tready, 0);
        end
        @(posedge PCLK);
        #1 m_tready = 1'b1;
        wait_drain("t3", 50);

        // Burst limit of 4 with a competing source
        do_reset();
        m_tready = 1'b1;
        @(negedge PCLK);
        push_pkt(2, 8'h20, 10, 1'b0);
        push_pkt(3, 8'h30, 2, 1'b1);
        push_exp(8'h20, 4); push_exp(8'h30, 2); push_exp(8'h24, 4); push_exp(8'h28, 2);
        wait_drain("t4", 300);
        check_grants("t4", 4, 3'd2, 3'd3, 3'd2, 3'd2, 3'd0);

        // Idle timeout of 8 with src1 pending
        do_reset();
        m_tready = 1'b1;
        @(negedge PCLK);
        push_byte(0, 8'h5A, 1'b0);
        push_byte(1, 8'h6B, 1'b1);
        exp_q.push_back(8'h5A); exp_q.push_back(8'h6B);
        @(negedge PCLK);
        for (int c = 1; c <= 9; c++) begin
            @(negedge PCLK);
            check($sformatf("t5_c%0d_busy", c), busy, 1);
            check($sformatf("t5_c%0d_grant_id", c), grant_id, 0);
        end
        @(negedge PCLK);
        check("t5_c10_busy", busy, 0);
        @(negedge PCLK);
        check("t5_c11_busy", busy, 1);
        check("t5_c11_grant_id", grant_id, 1);
        wait_drain("t5", 50);

        // Reset mid-packet with a byte held in the output register
        do_reset();
        @(posedge PCLK);
        #1 m_tready = 1'b0;
        @(negedge PCLK);
        push_pkt(1, 8'h70, 4, 1'b1);
        repeat (3) @(negedge PCLK);
        check("t6_pre_m_tvalid", m_tvalid, 1);
        check("t6_pre_m_tdata", m_tdata, 8'h70);
        do_reset();
        m_tready = 1'b1;
        @(negedge PCLK);
        push_byte(1, 8'h80, 1'b1);
        push_byte(0, 8'h90, 1'b1);
        exp_q.push_back(8'h90); exp_q.push_back(8'h80);
        wait_drain("t6", 50);
        check_grants("t6", 2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
